// File: rtl/wb_regfile.sv
// wb_regfile: MEM/WB result latch, general register file and two bypassed decode read ports.
// Define WB_EARLY_FWD_EN to also forward the incoming result bus straight into the read ports.
module wb_regfile #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int REG_NUM = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    output logic [ADDR_W-1:0] wb_wd_o,
    output logic              wb_wreg_o,
    output logic [DATA_W-1:0] wb_wdata_o,
    output logic [31:0]       commit_cnt_o
);

    logic [ADDR_W-1:0] wb_wd_q, wb_wd_d;
    logic              wb_wreg_q, wb_wreg_d;
    logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;
    logic [31:0]       commit_cnt_q, commit_cnt_d;
    logic [DATA_W-1:0] regs_q [REG_NUM];
    logic              commit_en;

    // Flush beats stall: a flushed slot must never be re-committed.
    always_comb begin
        wb_wd_d    = wb_wd_q;
        wb_wreg_d  = wb_wreg_q;
        wb_wdata_d = wb_wdata_q;
        if (flush_i) begin
            wb_wd_d    = '0;
            wb_wreg_d  = 1'b0;
            wb_wdata_d = '0;
        end else if (!stall_i) begin
            wb_wd_d    = wd_i;
            wb_wreg_d  = wreg_i;
            wb_wdata_d = wdata_i;
        end
    end

    assign commit_en    = wb_wreg_q && (wb_wd_q != '0);
    assign commit_cnt_d = commit_en ? commit_cnt_q + 32'd1 : commit_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_wd_q      <= '0;
            wb_wreg_q    <= 1'b0;
            wb_wdata_q   <= '0;
            commit_cnt_q <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wb_wd_q      <= wb_wd_d;
            wb_wreg_q    <= wb_wreg_d;
            wb_wdata_q   <= wb_wdata_d;
            commit_cnt_q <= commit_cnt_d;
            if (commit_en) begin
                regs_q[wb_wd_q] <= wb_wdata_q;
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic re, input logic [ADDR_W-1:0] raddr);
        logic [DATA_W-1:0] rd;
        rd = '0;
        if (rst || !re || raddr == '0) begin
            rd = '0;
`ifdef WB_EARLY_FWD_EN
        end else if (!flush_i && wreg_i && wd_i == raddr) begin
            rd = wdata_i;
`endif
        end else if (wb_wreg_q && wb_wd_q == raddr) begin
            rd = wb_wdata_q;
        end else begin
            rd = regs_q[raddr];
        end
        return rd;
    endfunction

    assign rdata1_o     = read_port(re1_i, raddr1_i);
    assign rdata2_o     = read_port(re2_i, raddr2_i);
    assign wb_wd_o      = wb_wd_q;
    assign wb_wreg_o    = wb_wreg_q;
    assign wb_wdata_o   = wb_wdata_q;
    assign commit_cnt_o = commit_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios plus randomized traffic against an architectural model.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic        stall_i, flush_i;
    logic        re1_i, re2_i;
    logic [4:0]  raddr1_i, raddr2_i;
    logic [31:0] rdata1_o, rdata2_o;
    logic [4:0]  wb_wd_o;
    logic        wb_wreg_o;
    logic [31:0] wb_wdata_o;
    logic [31:0] commit_cnt_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Architectural model: pending writeback slot, register contents, commit counter.
    logic [4:0]  m_wd;
    logic        m_wreg;
    logic [31:0] m_wdata;
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;

    wb_regfile dut (
        .clk(clk), .rst(rst),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .re1_i(re1_i), .raddr1_i(raddr1_i), .rdata1_o(rdata1_o),
        .re2_i(re2_i), .raddr2_i(raddr2_i), .rdata2_o(rdata2_o),
        .wb_wd_o(wb_wd_o), .wb_wreg_o(wb_wreg_o), .wb_wdata_o(wb_wdata_o),
        .commit_cnt_o(commit_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_wd = '0; m_wreg = 1'b0; m_wdata = '0; m_cnt = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
    endtask

    function automatic logic [31:0] model_read(input logic re, input logic [4:0] a);
        if (rst || !re || a == 5'd0) return 32'd0;
`ifdef WB_EARLY_FWD_EN
        if (!flush_i && wreg_i && wd_i == a) return wdata_i;
`endif
        if (m_wreg && m_wd == a) return m_wdata;
        return m_regs[a];
    endfunction

    task automatic idle_inputs();
        wd_i = '0; wreg_i = 1'b0; wdata_i = '0; stall_i = 1'b0; flush_i = 1'b0;
    endtask

    // One clock: advance model with the inputs presented this cycle, return at negedge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (m_wreg && m_wd != 5'd0) begin
                m_regs[m_wd] = m_wdata;
                m_cnt = m_cnt + 32'd1;
            end
            if (flush_i) begin
                m_wd = '0; m_wreg = 1'b0; m_wdata = '0;
            end else if (!stall_i) begin
                m_wd = wd_i; m_wreg = wreg_i; m_wdata = wdata_i;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; idle_inputs();
        re1_i = 1'b1; re2_i = 1'b1; raddr1_i = 5'd5; raddr2_i = 5'd1;
        model_reset();
        tick(); tick();
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({wb_wd_o, wb_wreg_o, wb_wdata_o, commit_cnt_o, rdata1_o, rdata2_o} !== '0)
            $display("FAIL reset_init: wd=%0d wreg=%0b wdata=%h cnt=%0d rd1=%h rd2=%h, required all 0",
                     wb_wd_o, wb_wreg_o, wb_wdata_o, commit_cnt_o, rdata1_o, rdata2_o);
        else pass_cnt++;
        @(negedge clk);
        // Load r5 into the latch, then reset before it can commit.
        wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h1234;
        tick();
        idle_inputs();
        #2 rst = 1'b1;
        model_reset();
        #1;
        total_cnt++;
        if ({wb_wd_o, wb_wreg_o, wb_wdata_o, commit_cnt_o, rdata1_o, rdata2_o} !== '0)
            $display("FAIL reset_midrun: wd=%0d wreg=%0b wdata=%h cnt=%0d rd1=%h rd2=%h, required all 0",
                     wb_wd_o, wb_wreg_o, wb_wdata_o, commit_cnt_o, rdata1_o, rdata2_o);
        else pass_cnt++;
        tick();
        rst = 1'b0;
        tick();
        #1;
        total_cnt++;
        if (rdata1_o !== 32'h0 || commit_cnt_o !== 32'd0)
            $display("FAIL reset_r5: r5=%h cnt=%0d, required 0 and 0", rdata1_o, commit_cnt_o);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_write_latency();
        wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'hDEADBEEF;
        tick();
        idle_inputs();
        re1_i = 1'b1; re2_i = 1'b1; raddr1_i = 5'd3; raddr2_i = 5'd3;
        #1;
        total_cnt++;
        if (rdata1_o !== 32'hDEADBEEF || rdata2_o !== 32'hDEADBEEF || commit_cnt_o !== 32'd0)
            $display("FAIL bypass_n1: rd1=%h rd2=%h cnt=%0d, required deadbeef deadbeef 0", rdata1_o, rdata2_o, commit_cnt_o);
        else pass_cnt++;
        tick();
        #1;
        total_cnt++;
        if (rdata1_o !== 32'hDEADBEEF || rdata2_o !== 32'hDEADBEEF || commit_cnt_o !== 32'd1 || wb_wreg_o !== 1'b0)
            $display("FAIL array_n2: rd1=%h rd2=%h cnt=%0d wreg=%0b, required deadbeef deadbeef 1 0",
                     rdata1_o, rdata2_o, commit_cnt_o, wb_wreg_o);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reg0();
        logic [31:0] c;
        c = m_cnt;
        wd_i = 5'd0; wreg_i = 1'b1; wdata_i = 32'hFFFFFFFF;
        tick();
        idle_inputs();
        raddr1_i = 5'd0; raddr2_i = 5'd0;
        #1;
        total_cnt++;
        if (wb_wd_o !== 5'd0 || wb_wreg_o !== 1'b1 || wb_wdata_o !== 32'hFFFFFFFF || rdata1_o !== 32'd0 || rdata2_o !== 32'd0)
            $display("FAIL reg0_latch: wd=%0d wreg=%0b wdata=%h rd1=%h rd2=%h, required 0 1 ffffffff 0 0",
                     wb_wd_o, wb_wreg_o, wb_wdata_o, rdata1_o, rdata2_o);
        else pass_cnt++;
        tick();
        #1;
        total_cnt++;
        if (commit_cnt_o !== c || rdata1_o !== 32'd0)
            $display("FAIL reg0_nocommit: cnt=%0d rd1=%h, required %0d 0", commit_cnt_o, rdata1_o, c);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_stall();
        logic [31:0] c;
        c = m_cnt;
        wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'h55;
        tick();
        stall_i = 1'b1; wdata_i = 32'hAA;
        for (int k = 0; k < 3; k++) begin
            tick();
            total_cnt++;
            if (wb_wdata_o !== 32'h55 || wb_wd_o !== 5'd7)
                $display("FAIL stall_hold%0d: wdata=%h wd=%0d, required 55 7", k, wb_wdata_o, wb_wd_o);
            else pass_cnt++;
        end
        idle_inputs();
        tick();
        raddr1_i = 5'd7; raddr2_i = 5'd7;
        #1;
        total_cnt++;
        if (rdata1_o !== 32'h55 || rdata2_o !== 32'h55 || commit_cnt_o !== c + 32'd4)
            $display("FAIL stall_commit: rd1=%h rd2=%h cnt=%0d, required 55 55 %0d", rdata1_o, rdata2_o, commit_cnt_o, c + 32'd4);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_flush_stall();
        logic [31:0] c;
        c = m_cnt;
        wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'h99; stall_i = 1'b1; flush_i = 1'b1;
        tick();
        idle_inputs();
        total_cnt++;
        if (wb_wreg_o !== 1'b0 || wb_wd_o !== 5'd0 || wb_wdata_o !== 32'd0)
            $display("FAIL flush_bubble: wreg=%0b wd=%0d wdata=%h, required 0 0 0", wb_wreg_o, wb_wd_o, wb_wdata_o);
        else pass_cnt++;
        tick();
        raddr1_i = 5'd9;
        #1;
        total_cnt++;
        if (rdata1_o !== 32'd0 || commit_cnt_o !== c)
            $display("FAIL flush_nocommit: r9=%h cnt=%0d, required 0 %0d", rdata1_o, commit_cnt_o, c);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_early_fwd();
        logic [31:0] exp_fwd;
`ifdef WB_EARLY_FWD_EN
        exp_fwd = 32'h11;
`else
        exp_fwd = 32'h22;
`endif
        wd_i = 5'd4; wreg_i = 1'b1; wdata_i = 32'h22;
        tick();
        wdata_i = 32'h11;
        raddr1_i = 5'd4; raddr2_i = 5'd4;
        #1;
        total_cnt++;
        if (rdata1_o !== exp_fwd || rdata2_o !== exp_fwd)
            $display("FAIL early_fwd: rd1=%h rd2=%h, required %h", rdata1_o, rdata2_o, exp_fwd);
        else pass_cnt++;
        flush_i = 1'b1;
        #1;
        total_cnt++;
        if (rdata1_o !== 32'h22 || rdata2_o !== 32'h22)
            $display("FAIL early_fwd_flush: rd1=%h rd2=%h, required 22", rdata1_o, rdata2_o);
        else pass_cnt++;
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int n = 0; n < 400; n++) begin
            wd_i     = 5'($urandom_range(0, 31));
            wreg_i   = ($urandom_range(0, 3) != 0);
            wdata_i  = $urandom;
            stall_i  = ($urandom_range(0, 7) == 0);
            flush_i  = ($urandom_range(0, 15) == 0);
            re1_i    = ($urandom_range(0, 7) != 0);
            re2_i    = ($urandom_range(0, 7) != 0);
            raddr1_i = ($urandom_range(0, 2) == 0) ? m_wd : 5'($urandom_range(0, 31));
            raddr2_i = ($urandom_range(0, 2) == 0) ? wd_i : raddr1_i ^ 5'($urandom_range(0, 3));
            #1;
            total_cnt++;
            if (rdata1_o !== model_read(re1_i, raddr1_i) || rdata2_o !== model_read(re2_i, raddr2_i)) begin
                if (errs < 10)
                    $display("FAIL rand_read@%0d: rd1=%h rd2=%h, required %h %h", n, rdata1_o, rdata2_o,
                             model_read(re1_i, raddr1_i), model_read(re2_i, raddr2_i));
                errs++;
            end else pass_cnt++;
            tick();
            total_cnt++;
            if (wb_wd_o !== m_wd || wb_wreg_o !== m_wreg || wb_wdata_o !== m_wdata || commit_cnt_o !== m_cnt) begin
                if (errs < 10)
                    $display("FAIL rand_state@%0d: wd=%0d wreg=%0b wdata=%h cnt=%0d, required %0d %0b %h %0d", n,
                             wb_wd_o, wb_wreg_o, wb_wdata_o, commit_cnt_o, m_wd, m_wreg, m_wdata, m_cnt);
                errs++;
            end else pass_cnt++;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_latency();
        test_reg0();
        test_stall();
        test_flush_stall();
        test_early_fwd();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
